// File: rtl/ws2812b_write_arbiter.sv
// ws2812b_write_arbiter
// Shares the frame-buffer write port of the WS2812B strip driver between
// NB_REQ requesters (round-robin, one write per cycle) and a built-in fill
// engine that paints every LED with one color while locking requesters out.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is combinational)
//   req_led, req_color    per-requester index / GRB color, packed slices
//   fill_start/fill_color start a fill; color sampled on the start cycle
//   fill_busy, fill_done  fill running / one-cycle completion pulse
//   wr_en/wr_led/wr_color registered write strobe towards the driver
//   err_oob               one-cycle pulse for an accepted out-of-range index
//   err_cnt               (only with WS_ARB_ERR_CNT_EN) saturating count of
//                         err_oob pulses
//
// Optional feature macro: WS_ARB_ERR_CNT_EN
//
// state | meaning
// ARB   | round-robin arbitration among requesters
// FILL  | fill engine owns the write port, requesters stalled
module ws2812b_write_arbiter #(
  parameter int NB_REQ  = 2,
  parameter int NB_LEDS = 5,
  parameter int IDX_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NB_REQ-1:0]         req_valid,
  output logic [NB_REQ-1:0]         req_ready,
  input  logic [NB_REQ*IDX_W-1:0]   req_led,
  input  logic [NB_REQ*24-1:0]      req_color,
  input  logic                      fill_start,
  input  logic [23:0]               fill_color,
  output logic                      fill_busy,
  output logic                      fill_done,
  output logic                      wr_en,
  output logic [IDX_W-1:0]          wr_led,
  output logic [23:0]               wr_color,
`ifdef WS_ARB_ERR_CNT_EN
  output logic                      err_oob,
  output logic [15:0]               err_cnt
`else
  output logic                      err_oob
`endif
);

  localparam int PTR_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int CNT_W = $clog2(NB_LEDS) + 1;
  localparam logic [IDX_W-1:0] LED_LIMIT = IDX_W'(NB_LEDS);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(NB_LEDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(NB_LEDS - 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [23:0]        fill_color_q, fill_color_d;
  logic               wr_en_q, wr_en_d;
  logic [IDX_W-1:0]   wr_led_q, wr_led_d;
  logic [23:0]        wr_color_q, wr_color_d;
  logic               fill_done_q, fill_done_d;
  logic               err_oob_q, err_oob_d;
`ifdef WS_ARB_ERR_CNT_EN
  logic [15:0]        err_cnt_q, err_cnt_d;
`endif

  logic [IDX_W-1:0]   led_arr [NB_REQ];
  logic [23:0]        color_arr [NB_REQ];
  logic               gnt_any;
  logic               hi_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [PTR_W-1:0]   hi_idx;
  logic [IDX_W-1:0]   sel_led;
  logic [23:0]        sel_color;

  for (genvar g = 0; g < NB_REQ; g++) begin : g_unpack
    assign led_arr[g]   = req_led[g*IDX_W +: IDX_W];
    assign color_arr[g] = req_color[g*24 +: 24];
  end

  // Round-robin: lowest valid index above the last winner, otherwise wrap to
  // the lowest valid index overall. The loop runs downward so the lowest
  // matching index is the one left assigned.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    hi_any  = 1'b0;
    hi_idx  = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(i);
        if (PTR_W'(i) > last_q) begin
          hi_any = 1'b1;
          hi_idx = PTR_W'(i);
        end
      end
    end
    if (hi_any) begin
      gnt_idx = hi_idx;
    end
  end

  assign sel_led   = led_arr[gnt_idx];
  assign sel_color = color_arr[gnt_idx];

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    fill_cnt_d   = fill_cnt_q;
    fill_color_d = fill_color_q;
    wr_en_d      = 1'b0;
    wr_led_d     = wr_led_q;
    wr_color_d   = wr_color_q;
    fill_done_d  = 1'b0;
    err_oob_d    = 1'b0;
    req_ready    = '0;

    case (state_q)
      ST_ARB: begin
        if (fill_start) begin
          // LED 0 is issued straight from the start cycle so the first write
          // lands one cycle after fill_start.
          state_d      = ST_FILL;
          fill_color_d = fill_color;
          fill_cnt_d   = CNT_W'(1);
          wr_en_d      = 1'b1;
          wr_led_d     = '0;
          wr_color_d   = fill_color;
          fill_done_d  = (NB_LEDS == 1);
        end else if (gnt_any) begin
          req_ready[gnt_idx] = 1'b1;
          last_d             = gnt_idx;
          if (sel_led < LED_LIMIT) begin
            wr_en_d    = 1'b1;
            wr_led_d   = sel_led;
            wr_color_d = sel_color;
          end else begin
            err_oob_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (fill_cnt_q < CNT_END) begin
          wr_en_d     = 1'b1;
          wr_led_d    = IDX_W'(fill_cnt_q);
          wr_color_d  = fill_color_q;
          fill_cnt_d  = fill_cnt_q + CNT_W'(1);
          fill_done_d = (fill_cnt_q == CNT_LAST);
        end else begin
          // Last LED already written; stay busy this cycle, then hand back.
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

`ifdef WS_ARB_ERR_CNT_EN
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_oob_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_ARB;
      last_q       <= PTR_W'(NB_REQ - 1);
      fill_cnt_q   <= '0;
      fill_color_q <= '0;
      wr_en_q      <= 1'b0;
      wr_led_q     <= '0;
      wr_color_q   <= '0;
      fill_done_q  <= 1'b0;
      err_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_color_q <= fill_color_d;
      wr_en_q      <= wr_en_d;
      wr_led_q     <= wr_led_d;
      wr_color_q   <= wr_color_d;
      fill_done_q  <= fill_done_d;
      err_oob_q    <= err_oob_d;
    end
  end

  assign fill_busy = (state_q == ST_FILL);
  assign fill_done = fill_done_q;
  assign wr_en     = wr_en_q;
  assign wr_led    = wr_led_q;
  assign wr_color  = wr_color_q;
  assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_ws2812b_write_arbiter.sv
// Testbench for ws2812b_write_arbiter: randomized and directed stimulus,
// expected outputs queued in a scoreboard and checked by a separate monitor.
module tb_ws2812b_write_arbiter;

  localparam int NB_REQ  = 2;
  localparam int NB_LEDS = 5;
  localparam int IDX_W   = 32;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NB_REQ-1:0]       req_valid;
  logic [NB_REQ-1:0]       req_ready;
  logic [NB_REQ*IDX_W-1:0] req_led;
  logic [NB_REQ*24-1:0]    req_color;
  logic                    fill_start;
  logic [23:0]             fill_color;
  logic                    fill_busy;
  logic                    fill_done;
  logic                    wr_en;
  logic [IDX_W-1:0]        wr_led;
  logic [23:0]             wr_color;
  logic                    err_oob;
`ifdef WS_ARB_ERR_CNT_EN
  logic [15:0]             err_cnt;
`endif

  ws2812b_write_arbiter #(.NB_REQ(NB_REQ), .NB_LEDS(NB_LEDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_led(req_led), .req_color(req_color),
    .fill_start(fill_start), .fill_color(fill_color),
    .fill_busy(fill_busy), .fill_done(fill_done),
    .wr_en(wr_en), .wr_led(wr_led), .wr_color(wr_color),
`ifdef WS_ARB_ERR_CNT_EN
    .err_oob(err_oob), .err_cnt(err_cnt)
`else
    .err_oob(err_oob)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_err;
    logic [31:0] led;
    logic [23:0] color;
    bit          done;
    int          ecnt;
  } item_t;

  item_t sb[$];
  int    total = 0;
  int    bad   = 0;
  bit    mon_en = 1'b0;

  // reference model state
  int          m_last;
  int          m_fill;
  int          m_ecnt;
  bit          pv [NB_REQ];
  logic [31:0] pl [NB_REQ];
  logic [23:0] pc [NB_REQ];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // monitor: compares whatever the DUT presents against the queue head
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          it = sb.pop_front();
          chk("missed_output", 32'd0, 32'd1);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
          it = sb.pop_front();
          chk("wr_en", {31'd0, wr_en}, {31'd0, !it.is_err});
          chk("err_oob", {31'd0, err_oob}, {31'd0, it.is_err});
          chk("fill_done", {31'd0, fill_done}, {31'd0, it.done});
          if (!it.is_err) begin
            chk("wr_led", wr_led, it.led);
            chk("wr_color", {8'd0, wr_color}, {8'd0, it.color});
          end
`ifdef WS_ARB_ERR_CNT_EN
          else chk("err_cnt", {16'd0, err_cnt}, it.ecnt);
`endif
        end else begin
          chk("idle_outputs", {29'd0, wr_en, err_oob, fill_done}, 32'd0);
        end
      end
    end
  end

  task automatic model_reset();
    item_t keep[$];
    m_last = NB_REQ - 1;
    m_fill = 0;
    m_ecnt = 0;
    foreach (sb[k]) if (sb[k].cyc <= cyc) keep.push_back(sb[k]);
    sb = keep;
  endtask

  // one clock cycle: drive at posedge+1, model and check ready at negedge
  task automatic step(input bit fs, input logic [23:0] fc, input bit r);
    logic [NB_REQ-1:0] exp_ready;
    int g;
    item_t it;
    rst        = r;
    fill_start = fs;
    fill_color = fc;
    for (int i = 0; i < NB_REQ; i++) begin
      req_valid[i]                = pv[i];
      req_led[i*IDX_W +: IDX_W]   = pl[i];
      req_color[i*24 +: 24]       = pc[i];
    end
    @(negedge clk);
    exp_ready = '0;
    g = -1;
    if (r) begin
      model_reset();
    end else begin
      chk("fill_busy", {31'd0, fill_busy}, {31'd0, (m_fill > 0)});
      if (m_fill > 0) begin
        m_fill--;
      end else if (fs) begin
        for (int k = 0; k < NB_LEDS; k++) begin
          it = '{cyc: cyc + 1 + k, is_err: 1'b0, led: k, color: fc,
                 done: (k == NB_LEDS - 1), ecnt: m_ecnt};
          sb.push_back(it);
        end
        m_fill = NB_LEDS;
      end else begin
        for (int k = 1; k <= NB_REQ; k++) begin
          int idx = (m_last + k) % NB_REQ;
          if (g < 0 && pv[idx]) g = idx;
        end
        if (g >= 0) begin
          exp_ready[g] = 1'b1;
          m_last = g;
          if (pl[g] >= NB_LEDS) begin
            if (m_ecnt < 65535) m_ecnt++;
            it = '{cyc: cyc + 1, is_err: 1'b1, led: pl[g], color: pc[g], done: 1'b0, ecnt: m_ecnt};
          end else begin
            it = '{cyc: cyc + 1, is_err: 1'b0, led: pl[g], color: pc[g], done: 1'b0, ecnt: m_ecnt};
          end
          sb.push_back(it);
          pv[g] = 1'b0;
        end
      end
      chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] led, input logic [23:0] col);
    pv[i] = 1'b1;
    pl[i] = led;
    pc[i] = col;
  endtask

  task automatic check_all_zero(string nm);
    chk({nm, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    chk({nm, "_wr_led"}, wr_led, 32'd0);
    chk({nm, "_wr_color"}, {8'd0, wr_color}, 32'd0);
    chk({nm, "_fill_busy"}, {31'd0, fill_busy}, 32'd0);
    chk({nm, "_fill_done"}, {31'd0, fill_done}, 32'd0);
    chk({nm, "_err_oob"}, {31'd0, err_oob}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NB_REQ; i++) begin
      pv[i] = 1'b0; pl[i] = '0; pc[i] = '0;
    end
    rst = 1'b1; fill_start = 1'b0; fill_color = '0;
    req_valid = '0; req_led = '0; req_color = '0;
    m_last = NB_REQ - 1; m_fill = 0; m_ecnt = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    mon_en = 1'b1;
    step(1'b0, 24'h0, 1'b1);
    check_all_zero("reset2");

    // single request
    set_req(0, 32'd2, 24'h00FF00);
    step(1'b0, 24'h0, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    step(1'b0, 24'h0, 1'b0);

    // contention right after reset: both held valid
    step(1'b0, 24'h0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      if (!pv[0]) set_req(0, 32'(n % NB_LEDS), 24'h110000 + 24'(n));
      if (!pv[1]) set_req(1, 32'((n + 2) % NB_LEDS), 24'h002200 + 24'(n));
      step(1'b0, 24'h0, 1'b0);
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    step(1'b0, 24'h0, 1'b0);

    // out of range on requester 1
    set_req(1, 32'd5, 24'hABCDEF);
    step(1'b0, 24'h0, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    set_req(0, 32'hFFFF_FFFF, 24'h123456);
    step(1'b0, 24'h0, 1'b0);
    step(1'b0, 24'h0, 1'b0);

    // fill while req0 waits
    set_req(0, 32'd1, 24'h0000FF);
    step(1'b1, 24'hFF0000, 1'b0);
    for (int n = 0; n < NB_LEDS + 2; n++) step(1'b0, 24'h0, 1'b0);

    // fill re-pulsed at fill cycle 2 is ignored
    set_req(1, 32'd4, 24'h00AA00);
    step(1'b1, 24'h0F0F0F, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    step(1'b1, 24'hFFFFFF, 1'b0);
    for (int n = 0; n < NB_LEDS + 2; n++) step(1'b0, 24'h0, 1'b0);

    // reset at fill cycle 3 aborts the fill
    set_req(0, 32'd3, 24'h330033);
    set_req(1, 32'd0, 24'h440044);
    step(1'b1, 24'h00FFFF, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    pv[0] = 1'b0; pv[1] = 1'b0;
    step(1'b0, 24'h0, 1'b1);
    check_all_zero("fill_abort");
    set_req(0, 32'd3, 24'h330033);
    set_req(1, 32'd0, 24'h440044);
    step(1'b0, 24'h0, 1'b0);
    step(1'b0, 24'h0, 1'b0);
    step(1'b0, 24'h0, 1'b0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit fs, r;
      for (int i = 0; i < NB_REQ; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0)
          set_req(i, 32'($urandom_range(0, 6)), 24'($urandom));
      end
      fs = ($urandom_range(0, 29) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(fs, 24'($urandom), r);
    end

    for (int i = 0; i < NB_REQ; i++) pv[i] = 1'b0;
    for (int n = 0; n < NB_LEDS + 3; n++) step(1'b0, 24'h0, 1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ws2812b_write_arbiter.md
Name: ws2812b_write_arbiter

Overview:
- Shares the single frame-buffer write port of the WS2812B strip driver (write / LED index / 24-bit GRB color) between NB_REQ independent requesters, e.g. the UART host and the pattern generator.
- Round-robin arbitration, one write per cycle, with out-of-range index rejection.
- Includes a built-in fill engine that paints the whole strip with one color, locking out requesters while it runs.
- Sits between the requesters and the driver; the driver keeps refreshing the strip on its own.

Parameters:
- NB_REQ, 2, number of requesters (2..8)
- NB_LEDS, 5, LED count of the attached driver; valid indices are 0..NB_LEDS-1
- IDX_W, 32, LED index width, matching the driver index port

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NB_REQ  per-requester write request
- req_ready  out  NB_REQ  per-requester accept
- req_led  in  NB_REQ*IDX_W  per-requester LED index; requester i occupies slice [i*IDX_W +: IDX_W]
- req_color  in  NB_REQ*24  per-requester color; slice [i*24 +: 24]
- fill_start  in  1  pulse: paint all LEDs with fill_color
- fill_color  in  24  fill color, sampled on the fill_start cycle
- fill_busy  out  1  fill engine running
- fill_done  out  1  one-cycle pulse when the fill completes
- wr_en  out  1  driver write strobe
- wr_led  out  IDX_W  driver LED index
- wr_color  out  24  driver color
- err_oob  out  1  one-cycle pulse: accepted request had index >= NB_LEDS

Behaviour:
- Reset values: wr_en, wr_led, wr_color, fill_busy, fill_done and err_oob all 0.
- Reset state is ARB. The round-robin pointer resets to NB_REQ-1, so requester 0 wins first.
- States:
  - ARB: arbitrate among requesters.
  - FILL: fill engine owns the write port.
- ARB, grant rule:
  - grant = first i with req_valid[i]=1, searching from (last+1) mod NB_REQ with wrap-around.
  - req_ready is combinational: 1 only on the granted bit; all 0 if no valid.
  - A transfer occurs when valid & ready. At most one transfer per cycle.
  - last <= granted index on each transfer only; idle cycles leave the pointer unchanged.
- ARB, write output:
  - Transfer at cycle N -> wr_en=1 at N+1 with the registered wr_led/wr_color of the accepted request.
  - wr_en is 0 in every other cycle.
- Out-of-range index (req_led >= NB_LEDS, unsigned compare):
  - The request is still accepted (ready=1) and the pointer still advances.
  - No write: wr_en stays 0 at N+1.
  - err_oob=1 at N+1 for exactly one cycle.
- Fill start:
  - fill_start=1 in ARB has priority over requesters: req_ready is forced to 0 in that same cycle.
  - fill_color is latched and the state goes to FILL.
- FILL:
  - req_ready is all 0 and fill_busy=1.
  - One write per cycle, wr_led = 0,1,...,NB_LEDS-1, each carrying the latched color.
  - fill_start at cycle N -> led 0 at N+1 -> last led at N+NB_LEDS.
  - fill_done=1 in the same cycle as the last write.
  - Returns to ARB the next cycle; fill_busy=0 from N+NB_LEDS+1.
  - The round-robin pointer is unchanged by a fill.
- fill_start asserted while in FILL is ignored: no restart, no queueing.
- Requesters hold valid and stable data until accepted. The arbiter never drops a valid request, except for out-of-range indices, which are consumed.
- Reset mid-fill: the fill aborts immediately, no fill_done, all outputs 0 next cycle, state ARB.
- Reset in the same cycle as a transfer: the transfer is discarded and no wr_en follows.
- Width: the fill index counter is $clog2(NB_LEDS)+1 bits and is zero-extended to IDX_W on wr_led.

Optional Feature:
- Macro: WS_ARB_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt, 16 bits.
  - Increments on every err_oob pulse and saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single request: req0 valid with led=2, color=24'h00FF00 -> req_ready[0]=1 the same cycle; next cycle wr_en=1, wr_led=2, wr_color=24'h00FF00; then wr_en=0.
- Contention: req0 and req1 held valid continuously after reset -> grants alternate 0,1,0,1 over 4 cycles, giving 4 consecutive wr_en pulses with matching indices and colors.
- Out of range: req1 with led=5 (NB_LEDS=5) -> accepted; next cycle err_oob=1 and wr_en=0; err_cnt=1 when WS_ARB_ERR_CNT_EN is defined.
- Fill: fill_start with fill_color=24'hFF0000 while req0 is valid:
  - req_ready=0 throughout the fill.
  - wr_led 0..4 on 5 consecutive cycles, all with color FF0000.
  - fill_done coincides with led 4; fill_busy high for 5 cycles.
  - req0 is accepted on the cycle after the fill ends.
- Fill ignored and reset abort: fill_start re-pulsed at fill cycle 2 -> sequence unaffected. In a second run, rst asserted at fill cycle 3 -> no fill_done, all outputs 0 next cycle, req0 is granted first after reset.
